cache_controller: RTL and testbench

- 2-way set-associative, write-through, no-write-allocate data cache between the EXE stage register output and the SRAM controller.
- Read hits complete in the same cycle; misses and all writes go to SRAM through the existing controller handshake.
- readyOut drives the pipeline freeze in place of the SRAM controller's ready.

---
 rtl/cache_controller.sv | 205 ++++++++++++++++++++
 tb/tb_cache_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache in front of the SRAM controller.
// Define CACHE_STATS_EN to build the saturating read hit/miss counters; otherwise both read 0.
module cache_controller #(
    parameter int SETS    = 64,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEnIn,
    input  logic        wrEnIn,
    input  logic [31:0] addressIn,
    input  logic [31:0] writeDataIn,
    output logic [31:0] readDataOut,
    output logic        readyOut,
    output logic        sramRdEnOut,
    output logic        sramWrEnOut,
    output logic [31:0] sramAddressOut,
    output logic [31:0] sramWriteDataOut,
    input  logic [63:0] sramReadDataIn,
    input  logic        sramReadyIn,
    output logic [15:0] hitCountOut,
    output logic [15:0] missCountOut
);

    typedef enum logic [1:0] {IDLE, MISS_RD, WRITE} state_t;

    state_t state_reg, state_next;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               word_sel;
    logic               unused_addr_bits;

    assign index            = addressIn[3 +: INDEX_W];
    assign tag              = addressIn[9 +: TAG_W];
    assign word_sel         = addressIn[2];
    assign unused_addr_bits = ^{addressIn[31:9+TAG_W], addressIn[1:0]};

    logic [1:0]       way_valid;
    logic [TAG_W-1:0] way_tag  [2];
    logic [63:0]      way_data [2];
    logic [SETS-1:0]  lru_reg;

    logic        hit0, hit1, hit, hit_way, victim_way;
    logic [63:0] hit_data;
    logic [31:0] hit_word;
    logic        rd_req, read_hit_done, fill_en, wr_hit_en;

    assign hit0       = way_valid[0] && (way_tag[0] == tag);
    assign hit1       = way_valid[1] && (way_tag[1] == tag);
    assign hit        = hit0 || hit1;
    assign hit_way    = !hit0;
    assign hit_data   = hit0 ? way_data[0] : way_data[1];
    assign hit_word   = word_sel ? hit_data[63:32] : hit_data[31:0];
    // Invalid ways are filled before evicting; lru bit set means way0 is the older one.
    assign victim_way = !way_valid[0] ? 1'b0 :
                        !way_valid[1] ? 1'b1 : !lru_reg[index];

    assign rd_req        = rdEnIn && !wrEnIn;
    assign read_hit_done = (state_reg == IDLE) && rd_req && hit;
    assign fill_en       = (state_reg == MISS_RD) && sramReadyIn;
    assign wr_hit_en     = (state_reg == WRITE) && sramReadyIn && hit;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_way
            localparam bit WAY_ID = (gi == 1);

            logic [TAG_W-1:0] tag_mem [SETS];
            logic [31:0]      lo_mem  [SETS];
            logic [31:0]      hi_mem  [SETS];
            logic [SETS-1:0]  valid_reg;
            logic             fill_sel, wr_sel;

            assign fill_sel = fill_en && (victim_way == WAY_ID);
            assign wr_sel   = wr_hit_en && (hit_way == WAY_ID);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_reg <= '0;
                end else if (fill_sel) begin
                    valid_reg[index] <= 1'b1;
                end
            end

            // Storage carries no reset; validity alone decides whether contents are meaningful.
            always_ff @(posedge clk) begin
                if (rst && fill_sel) begin
                    tag_mem[index] <= tag;
                    lo_mem[index]  <= sramReadDataIn[31:0];
                    hi_mem[index]  <= sramReadDataIn[63:32];
                end else if (rst && wr_sel) begin
                    if (word_sel) begin
                        hi_mem[index] <= writeDataIn;
                    end else begin
                        lo_mem[index] <= writeDataIn;
                    end
                end
            end

            assign way_valid[gi] = valid_reg[index];
            assign way_tag[gi]   = tag_mem[index];
            assign way_data[gi]  = {hi_mem[index], lo_mem[index]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            lru_reg <= '0;
        end else if (fill_en) begin
            lru_reg[index] <= victim_way;
        end else if (read_hit_done || wr_hit_en) begin
            lru_reg[index] <= hit_way;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (wrEnIn) begin
                    state_next = WRITE;
                end else if (rdEnIn && !hit) begin
                    state_next = MISS_RD;
                end
            end
            MISS_RD, WRITE: begin
                if (sramReadyIn) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        readyOut         = 1'b1;
        readDataOut      = 32'd0;
        sramRdEnOut      = 1'b0;
        sramWrEnOut      = 1'b0;
        sramAddressOut   = 32'd0;
        sramWriteDataOut = 32'd0;
        case (state_reg)
            IDLE: begin
                if (wrEnIn) begin
                    readyOut = 1'b0;
                end else if (rdEnIn) begin
                    if (hit) begin
                        readDataOut = hit_word;
                    end else begin
                        readyOut = 1'b0;
                    end
                end
            end
            MISS_RD: begin
                sramRdEnOut    = 1'b1;
                sramAddressOut = addressIn;
                readyOut       = sramReadyIn;
                if (sramReadyIn) begin
                    readDataOut = word_sel ? sramReadDataIn[63:32] : sramReadDataIn[31:0];
                end
            end
            WRITE: begin
                sramWrEnOut      = 1'b1;
                sramAddressOut   = addressIn;
                sramWriteDataOut = writeDataIn;
                readyOut         = sramReadyIn;
            end
            default: ;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_reg, miss_count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count_reg  <= 16'd0;
            miss_count_reg <= 16'd0;
        end else begin
            if (read_hit_done && (hit_count_reg != 16'hFFFF)) begin
                hit_count_reg <= hit_count_reg + 16'd1;
            end
            if (fill_en && (miss_count_reg != 16'hFFFF)) begin
                miss_count_reg <= miss_count_reg + 16'd1;
            end
        end
    end

    assign hitCountOut  = hit_count_reg;
    assign missCountOut = miss_count_reg;
`else
    assign hitCountOut  = 16'd0;
    assign missCountOut = 16'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: misses, hits, replacement, write-through, mid-miss reset, stats.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        rdEnIn;
    logic        wrEnIn;
    logic [31:0] addressIn;
    logic [31:0] writeDataIn;
    logic [31:0] readDataOut;
    logic        readyOut;
    logic        sramRdEnOut;
    logic        sramWrEnOut;
    logic [31:0] sramAddressOut;
    logic [31:0] sramWriteDataOut;
    logic [63:0] sramReadDataIn;
    logic        sramReadyIn;
    logic [15:0] hitCountOut;
    logic [15:0] missCountOut;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_hits     = 0;
    int exp_misses   = 0;

    cache_controller dut (
        .clk              (clk),
        .rst              (rst),
        .rdEnIn           (rdEnIn),
        .wrEnIn           (wrEnIn),
        .addressIn        (addressIn),
        .writeDataIn      (writeDataIn),
        .readDataOut      (readDataOut),
        .readyOut         (readyOut),
        .sramRdEnOut      (sramRdEnOut),
        .sramWrEnOut      (sramWrEnOut),
        .sramAddressOut   (sramAddressOut),
        .sramWriteDataOut (sramWriteDataOut),
        .sramReadDataIn   (sramReadDataIn),
        .sramReadyIn      (sramReadyIn),
        .hitCountOut      (hitCountOut),
        .missCountOut     (missCountOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] blk(input logic [31:0] a);
        return {32'hB000_0000 | a, 32'hA000_0000 | a};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, readyOut}, 32'd1);
        check({tag, ".sram_rd"}, {31'd0, sramRdEnOut}, 32'd0);
        check({tag, ".sram_wr"}, {31'd0, sramWrEnOut}, 32'd0);
        check({tag, ".rdata"}, readDataOut, 32'd0);
        next_cycle();
    endtask

    // lat = number of cycles readyOut stays low on a miss (first one is the IDLE lookup cycle).
    task automatic do_read(input logic [31:0] addr, input bit exp_hit,
                           input logic [63:0] block, input int lat);
        logic [31:0] word;
        word      = addr[2] ? block[63:32] : block[31:0];
        rdEnIn    = 1'b1;
        addressIn = addr;
        if (exp_hit) begin
            @(negedge clk);
            check("hit.ready", {31'd0, readyOut}, 32'd1);
            check("hit.rdata", readDataOut, word);
            check("hit.sram_rd", {31'd0, sramRdEnOut}, 32'd0);
            exp_hits++;
            $display("[TB] read  %h hit  data %h", addr, readDataOut);
            next_cycle();
        end else begin
            @(negedge clk);
            check("miss.lookup_ready", {31'd0, readyOut}, 32'd0);
            check("miss.lookup_sram_rd", {31'd0, sramRdEnOut}, 32'd0);
            next_cycle();
            for (int i = 1; i < lat; i++) begin
                @(negedge clk);
                check("miss.wait_ready", {31'd0, readyOut}, 32'd0);
                check("miss.sram_rd", {31'd0, sramRdEnOut}, 32'd1);
                check("miss.sram_addr", sramAddressOut, addr);
                next_cycle();
            end
            sramReadyIn    = 1'b1;
            sramReadDataIn = block;
            @(negedge clk);
            check("miss.done_ready", {31'd0, readyOut}, 32'd1);
            check("miss.rdata", readDataOut, word);
            exp_misses++;
            $display("[TB] read  %h miss data %h", addr, readDataOut);
            next_cycle();
            sramReadyIn    = 1'b0;
            sramReadDataIn = 64'd0;
        end
        rdEnIn = 1'b0;
        @(negedge clk);
        check("after_read.sram_rd", {31'd0, sramRdEnOut}, 32'd0);
        next_cycle();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input bit also_rd, input int lat);
        wrEnIn      = 1'b1;
        rdEnIn      = also_rd;
        addressIn   = addr;
        writeDataIn = data;
        @(negedge clk);
        check("wr.lookup_ready", {31'd0, readyOut}, 32'd0);
        check("wr.lookup_sram_wr", {31'd0, sramWrEnOut}, 32'd0);
        next_cycle();
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check("wr.wait_ready", {31'd0, readyOut}, 32'd0);
            check("wr.sram_wr", {31'd0, sramWrEnOut}, 32'd1);
            check("wr.sram_rd", {31'd0, sramRdEnOut}, 32'd0);
            check("wr.sram_addr", sramAddressOut, addr);
            check("wr.sram_wdata", sramWriteDataOut, data);
            next_cycle();
        end
        sramReadyIn = 1'b1;
        @(negedge clk);
        check("wr.done_ready", {31'd0, readyOut}, 32'd1);
        check("wr.done_sram_wr", {31'd0, sramWrEnOut}, 32'd1);
        $display("[TB] write %h data %h", addr, data);
        next_cycle();
        sramReadyIn = 1'b0;
        wrEnIn      = 1'b0;
        rdEnIn      = 1'b0;
        @(negedge clk);
        check("after_write.sram_wr", {31'd0, sramWrEnOut}, 32'd0);
        next_cycle();
    endtask

    task automatic check_stats();
`ifdef CACHE_STATS_EN
        check("stats.hits", {16'd0, hitCountOut}, exp_hits[31:0]);
        check("stats.misses", {16'd0, missCountOut}, exp_misses[31:0]);
`else
        check("stats.hits_off", {16'd0, hitCountOut}, 32'd0);
        check("stats.misses_off", {16'd0, missCountOut}, 32'd0);
`endif
    endtask

    initial begin
        rst            = 1'b0;
        rdEnIn         = 1'b0;
        wrEnIn         = 1'b0;
        addressIn      = 32'd0;
        writeDataIn    = 32'd0;
        sramReadDataIn = 64'd0;
        sramReadyIn    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_check("reset");
        @(negedge clk);
        check_stats();
        next_cycle();

        // Cold miss with 3 low cycles, then hit on the other word of the block.
        do_read(32'h0000_0404, 1'b0, 64'h2222_2222_1111_1111, 3);
        do_read(32'h0000_0400, 1'b1, 64'h2222_2222_1111_1111, 0);

        // Set 0 replacement: 0x400 in way0, 0x200 fills way1 and becomes most recent.
        do_read(32'h0000_0200, 1'b0, blk(32'h200), 2);
        do_read(32'h0000_0200, 1'b1, blk(32'h200), 0);
        do_read(32'h0000_0600, 1'b0, blk(32'h600), 2);
        do_read(32'h0000_0200, 1'b1, blk(32'h200), 0);
        do_read(32'h0000_0400, 1'b0, 64'h2222_2222_1111_1111, 1);

        // Write-through hit updates one word only.
        do_write(32'h0000_0404, 32'hDEAD_BEEF, 1'b0, 3);
        do_read(32'h0000_0404, 1'b1, {32'hDEAD_BEEF, 32'h1111_1111}, 0);
        do_read(32'h0000_0400, 1'b1, {32'hDEAD_BEEF, 32'h1111_1111}, 0);

        // Write miss goes to SRAM without allocating.
        do_write(32'h0000_0800, 32'h1234_5678, 1'b0, 2);
        do_read(32'h0000_0800, 1'b0, blk(32'h800), 2);

        // Simultaneous read and write requests take the write path.
        do_write(32'h0000_0400, 32'h5555_AAAA, 1'b1, 2);
        do_read(32'h0000_0400, 1'b1, {32'hDEAD_BEEF, 32'h5555_AAAA}, 0);

        // Stray SRAM ready while idle changes nothing.
        sramReadyIn = 1'b1;
        idle_check("idle_sram_ready");
        sramReadyIn = 1'b0;
        @(negedge clk);
        check_stats();
        next_cycle();

        // Reset during a miss aborts it and invalidates the cache.
        do_read(32'h0000_0008, 1'b0, blk(32'h8), 2);
        do_read(32'h0000_0008, 1'b1, blk(32'h8), 0);
        rdEnIn    = 1'b1;
        addressIn = 32'h0000_0010;
        next_cycle();
        @(negedge clk);
        check("abort.sram_rd_before", {31'd0, sramRdEnOut}, 32'd1);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst        = 1'b1;
        rdEnIn     = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        $display("[TB] reset during miss");
        idle_check("abort");

        do_read(32'h0000_0008, 1'b0, blk(32'h8), 2);
        do_read(32'h0000_0008, 1'b1, blk(32'h8), 0);
        do_read(32'h0000_000C, 1'b1, blk(32'h8), 0);
        do_read(32'h0000_0008, 1'b1, blk(32'h8), 0);
        @(negedge clk);
        check_stats();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
